// File: rtl/rtm_bank_array.sv
// -----------------------------------------------------------------------------
// rtm_bank_array
//
// Array of NUM_BANKS fully independent single-port-per-direction memory banks.
// Each bank has its own read port (pipelined, latency RD_LAT = 1 + NUM_PIPE)
// and its own write port. After reset the array runs an INIT sweep that writes
// zero to every address of every bank, one address per cycle, and only then
// raises `ready` and starts accepting requests.
//
// Optional feature (compile-time macro):
//   RTM_WR_BYPASS_EN  defined   : same-cycle, same-bank, same-address
//                                 read/write returns the new write data
//                                 (write-first) through a registered mux.
//                     undefined : such a read returns the old contents
//                                 (read-first); no forwarding logic exists.
//
// Ports:
//   clk       in   single clock, rising edge
//   rstn      in   synchronous active-low reset
//   rd_en     in   [NUM_BANKS]            per-bank read request
//   rd_addr   in   [NUM_BANKS*AW]         per-bank read address, bank i at [i*AW +: AW]
//   dout      out  [NUM_BANKS*BANK_WIDTH] per-bank read data, held between results
//   dout_vld  out  [NUM_BANKS]            per-bank read-data valid, one pulse per read
//   wr_en     in   [NUM_BANKS]            per-bank write request
//   wr_addr   in   [NUM_BANKS*AW]         per-bank write address
//   din       in   [NUM_BANKS*BANK_WIDTH] per-bank write data
//   ready     out  high once the INIT clear has completed
// -----------------------------------------------------------------------------
module rtm_bank_array #(
   parameter  int NUM_BANKS  = 4,
   parameter  int BANK_WIDTH = 64,
   parameter  int DEPTH      = 4096,
   parameter  int NUM_PIPE   = 2,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [NUM_BANKS-1:0]            rd_en,
   input  logic [NUM_BANKS*AW-1:0]         rd_addr,
   output logic [NUM_BANKS*BANK_WIDTH-1:0] dout,
   output logic [NUM_BANKS-1:0]            dout_vld,
   input  logic [NUM_BANKS-1:0]            wr_en,
   input  logic [NUM_BANKS*AW-1:0]         wr_addr,
   input  logic [NUM_BANKS*BANK_WIDTH-1:0] din,
   output logic                            ready
);

   localparam int RD_LAT = 1 + NUM_PIPE;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          r_state;
   logic [AW-1:0]   r_init_cnt;
   logic            r_ready;
   logic            w_clr;

   // --------------------------------------------------------------------------
   // Control FSM: INIT sweeps every address once, then RUN until reset.
   // --------------------------------------------------------------------------
   // NOTE: sequential state is assigned with <= only, so every flop samples
   // the pre-edge value of every other flop regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
         r_ready    <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_init_cnt <= r_init_cnt + AW'(1);
               // The last clear write happens this cycle; ready rises with RUN.
               if (r_init_cnt == AW'(DEPTH - 1)) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign w_clr = (r_state == ST_INIT);
   assign ready = r_ready;

   // --------------------------------------------------------------------------
   // Banks
   // --------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank

      logic [BANK_WIDTH-1:0] r_mem [DEPTH];

      logic [AW-1:0]         w_raddr;
      logic [AW-1:0]         w_waddr_req;
      logic [BANK_WIDTH-1:0] w_din;
      logic                  w_rd_acc;
      logic                  w_wr_acc;

      logic                  w_mem_we;
      logic [AW-1:0]         w_mem_waddr;
      logic [BANK_WIDTH-1:0] w_mem_wdata;

      logic [RD_LAT-1:0]     r_vld;
      logic [BANK_WIDTH-1:0] r_data [RD_LAT];

      assign w_raddr     = rd_addr[gi*AW +: AW];
      assign w_waddr_req = wr_addr[gi*AW +: AW];
      assign w_din       = din[gi*BANK_WIDTH +: BANK_WIDTH];

      // Requests are only honoured once the clear sweep is finished.
      assign w_rd_acc = r_ready & rd_en[gi];
      assign w_wr_acc = r_ready & wr_en[gi];

      // The clear sweep owns the write port during INIT.
      assign w_mem_we    = w_clr | w_wr_acc;
      assign w_mem_waddr = w_clr ? r_init_cnt : w_waddr_req;
      assign w_mem_wdata = w_clr ? '0 : w_din;

`ifdef RTM_WR_BYPASS_EN
      logic w_byp_hit;
      assign w_byp_hit = w_rd_acc & w_wr_acc & (w_raddr == w_waddr_req);
`endif

      // NOTE: the storage array has no reset; its contents are defined by
      // the INIT sweep, which keeps it mappable onto plain RAM macros.
      always_ff @(posedge clk) begin
         if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
         end
      end

      // Read pipeline: stage 0 captures the RAM word, later stages shift.
      // Data registers load only alongside a valid, so the last stage (dout)
      // holds its value between results.
      always_ff @(posedge clk) begin
         if (!rstn) begin
            r_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
               r_data[k] <= '0;
            end
         end else begin
            r_vld[0] <= w_rd_acc;
            if (w_rd_acc) begin
`ifdef RTM_WR_BYPASS_EN
               // Write-first: forward the incoming word on an address hit.
               r_data[0] <= w_byp_hit ? w_din : r_mem[w_raddr];
`else
               // Read-first: the array still holds the old word this cycle.
               r_data[0] <= r_mem[w_raddr];
`endif
            end
            for (int k = 1; k < RD_LAT; k++) begin
               r_vld[k] <= r_vld[k-1];
               if (r_vld[k-1]) begin
                  r_data[k] <= r_data[k-1];
               end
            end
         end
      end

      assign dout[gi*BANK_WIDTH +: BANK_WIDTH] = r_data[RD_LAT-1];
      assign dout_vld[gi]                      = r_vld[RD_LAT-1];

   end : g_bank

endmodule : rtm_bank_array

// File: tb/tb_rtm_bank_array.sv
// -----------------------------------------------------------------------------
// tb_rtm_bank_array
//
// Directed bench for rtm_bank_array at its default configuration. Reads push
// their expected word and due cycle into a scoreboard queue; a negedge monitor
// compares dout_vld/dout of every bank against the queue each cycle, and checks
// that dout holds its last value between results.
// -----------------------------------------------------------------------------
module tb_rtm_bank_array;

   localparam int NB     = 4;
   localparam int BW     = 64;
   localparam int DEPTH  = 4096;
   localparam int NPIPE  = 2;
   localparam int AW     = $clog2(DEPTH);
   localparam int RD_LAT = 1 + NPIPE;
   localparam int CW     = NB * BW;

   logic              clk = 1'b0;
   logic              rstn;
   logic [NB-1:0]     rd_en;
   logic [NB*AW-1:0]  rd_addr;
   logic [CW-1:0]     dout;
   logic [NB-1:0]     dout_vld;
   logic [NB-1:0]     wr_en;
   logic [NB*AW-1:0]  wr_addr;
   logic [CW-1:0]     din;
   logic              ready;

   rtm_bank_array #(
      .NUM_BANKS  (NB),
      .BANK_WIDTH (BW),
      .DEPTH      (DEPTH),
      .NUM_PIPE   (NPIPE)
   ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .dout     (dout),
      .dout_vld (dout_vld),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .din      (din),
      .ready    (ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            due;
      int            bank;
      logic [BW-1:0] data;
   } exp_t;

   exp_t          exp_q [$];
   logic [BW-1:0] mem_model [int];
   logic [BW-1:0] last_d [NB];
   int            cyc      = 0;
   int            n_checks = 0;
   int            n_fail   = 0;
   bit            mon_en   = 1'b0;
   logic          mon_hit;
   logic [BW-1:0] mon_exp;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] mdl(input int b, input int a);
      if (mem_model.exists(b * DEPTH + a)) return mem_model[b * DEPTH + a];
      return '0;
   endfunction

   task automatic rd(input int b, input int a, input logic [BW-1:0] e);
      exp_t t;
      rd_en[b]             = 1'b1;
      rd_addr[b*AW +: AW]  = AW'(a);
      t.due  = cyc + RD_LAT;
      t.bank = b;
      t.data = e;
      exp_q.push_back(t);
   endtask

   task automatic wr(input int b, input int a, input logic [BW-1:0] d);
      wr_en[b]             = 1'b1;
      wr_addr[b*AW +: AW]  = AW'(a);
      din[b*BW +: BW]      = d;
      mem_model[b * DEPTH + a] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rd_en = '0;
      wr_en = '0;
   endtask

   task automatic drive_garbage();
      rd_en   = NB'($urandom);
      wr_en   = NB'($urandom);
      rd_addr = {$urandom, $urandom};
      wr_addr = {$urandom, $urandom};
      for (int k = 0; k < CW / 32; k++) din[k*32 +: 32] = $urandom;
   endtask

   // One-cycle reset pulse, then wait for ready. abort_at > 0 stops the wait
   // early (used to reset again in the middle of INIT).
   task automatic do_reset(input bit garbage, input int abort_at);
      int n;
      rstn = 1'b0;
      // Reads whose results are not yet visible are flushed by the reset.
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) void'(exp_q.pop_back());
      @(posedge clk);
      #1;
      rd_en  = '0;
      wr_en  = '0;
      rstn   = 1'b1;
      mon_en = 1'b1;
      foreach (last_d[b]) last_d[b] = '0;
      mem_model.delete();
      check("rst_dout", dout, '0);
      check("rst_dout_vld", CW'(dout_vld), '0);
      check("rst_ready", CW'(ready), '0);
      n = 0;
      while (ready === 1'b0 && n < 5000 && !(abort_at > 0 && n >= abort_at)) begin
         n++;
         if (garbage) drive_garbage();
         @(posedge clk);
         #1;
      end
      rd_en = '0;
      wr_en = '0;
      if (abort_at == 0) begin
         check("init_cycles", CW'(n), CW'(DEPTH));
         check("ready_up", CW'(ready), CW'(1));
      end
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int b = 0; b < NB; b++) begin
            mon_hit = 1'b0;
            mon_exp = '0;
            foreach (exp_q[k]) begin
               if (exp_q[k].due == cyc && exp_q[k].bank == b) begin
                  mon_hit = 1'b1;
                  mon_exp = exp_q[k].data;
               end
            end
            check($sformatf("dout_vld[%0d]@%0d", b, cyc), CW'(dout_vld[b]), CW'(mon_hit));
            if (mon_hit) begin
               check($sformatf("dout[%0d]@%0d", b, cyc), CW'(dout[b*BW +: BW]), CW'(mon_exp));
               last_d[b] = mon_exp;
            end else begin
               check($sformatf("hold[%0d]@%0d", b, cyc), CW'(dout[b*BW +: BW]), CW'(last_d[b]));
            end
         end
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [BW-1:0] d;
      logic [BW-1:0] e;
      int            op;
      int            a;
      int            wa;

      rstn    = 1'b0;
      rd_en   = '0;
      wr_en   = '0;
      rd_addr = '0;
      wr_addr = '0;
      din     = '0;
      foreach (last_d[b]) last_d[b] = '0;
      @(posedge clk);
      #1;

      // Reset, INIT length, requests ignored during INIT.
      do_reset(1'b1, 0);

      // Every location of every bank reads zero (includes bank 2 addr 0x7FF).
      for (int i = 0; i < DEPTH; i++) begin
         for (int b = 0; b < NB; b++) rd(b, i, mdl(b, i));
         step();
      end
      repeat (4) step();

      // Write then read on the following cycle.
      wr(0, 5, 64'hDEAD_BEEF_0000_0001);
      step();
      rd(0, 5, mdl(0, 5));
      step();
      repeat (4) step();

      // Fill addresses 0..15 on all banks, then stream them back.
      for (int i = 0; i < 16; i++) begin
         for (int b = 0; b < NB; b++) wr(b, i, {8'(8'hC0 + b), 24'h0, 32'(i) ^ 32'h1234_0000});
         step();
      end
      for (int i = 0; i < 16; i++) begin
         for (int b = 0; b < NB; b++) rd(b, i, mdl(b, i));
         step();
      end
      repeat (4) step();

      // Random mix of reads and writes across banks, including collisions.
      for (int i = 0; i < 32; i++) begin
         for (int b = 0; b < NB; b++) begin
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 7));
            wa = int'($urandom_range(0, 7));
            d  = {$urandom, $urandom};
            if (op[0]) begin
               e = mdl(b, a);
`ifdef RTM_WR_BYPASS_EN
               if (op[1] && wa == a) e = d;
`endif
               rd(b, a, e);
            end
            if (op[1]) wr(b, wa, d);
         end
         step();
      end
      repeat (4) step();

      // Same-cycle read/write collision on bank 1 address 9.
      wr(1, 9, {16{4'hA}});
      step();
`ifdef RTM_WR_BYPASS_EN
      e = {16{4'h5}};
`else
      e = {16{4'hA}};
`endif
      rd(1, 9, e);
      wr(1, 9, {16{4'h5}});
      step();
      rd(1, 9, mdl(1, 9));
      step();
      repeat (4) step();

      // Three reads in flight, reset before any result appears.
      rd(0, 5, mdl(0, 5));
      rd(1, 9, mdl(1, 9));
      step();
      rd(0, 1, mdl(0, 1));
      step();
      rd(2, 3, mdl(2, 3));
      do_reset(1'b0, 0);

      // Memory cleared again after reset.
      rd(0, 5, mdl(0, 5));
      rd(1, 9, mdl(1, 9));
      step();
      for (int i = 0; i < 16; i++) begin
         for (int b = 0; b < NB; b++) rd(b, i, mdl(b, i));
         step();
      end
      repeat (4) step();

      // Reset in the middle of INIT restarts the full clear.
      wr(3, 7, 64'h0123_4567_89AB_CDEF);
      step();
      do_reset(1'b1, 100);
      do_reset(1'b0, 0);
      rd(3, 7, mdl(3, 7));
      rd(2, DEPTH - 1, mdl(2, DEPTH - 1));
      step();
      repeat (5) step();

      check("queue_drained", CW'(exp_q.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rtm_bank_array

// File: doc/rtm_bank_array.md
RTM_BANK_ARRAY -- requirements
Module: rtm_bank_array

Interface
- REQ-001 SHALL expose parameter NUM_BANKS, default 4: number of independent banks.
- REQ-002 SHALL expose parameter BANK_WIDTH, default 64: bits per bank word, a multiple of 8.
- REQ-003 SHALL expose parameter DEPTH, default 4096: words per bank, a power of two, >= 2. AW = clog2(DEPTH).
- REQ-004 SHALL expose parameter NUM_PIPE, default 2: extra read-pipeline register stages. RD_LAT = 1 + NUM_PIPE.
- REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
- REQ-006 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
- REQ-007 SHALL have port rd_en, input, NUM_BANKS bits: per-bank read request.
- REQ-008 SHALL have port rd_addr, input, NUM_BANKS*AW bits: per-bank read address; bank i occupies slice [i*AW +: AW].
- REQ-009 SHALL have port dout, output, NUM_BANKS*BANK_WIDTH bits: per-bank read data.
- REQ-010 SHALL have port dout_vld, output, NUM_BANKS bits: per-bank read-data valid.
- REQ-011 SHALL have port wr_en, input, NUM_BANKS bits: per-bank write request.
- REQ-012 SHALL have port wr_addr, input, NUM_BANKS*AW bits: per-bank write address.
- REQ-013 SHALL have port din, input, NUM_BANKS*BANK_WIDTH bits: per-bank write data.
- REQ-014 SHALL have port ready, output, 1 bit: high when the array accepts requests, i.e. initialisation is complete.

Function
- REQ-015 SHALL use a two-state FSM.
  - INIT: entered on reset.
  - RUN: entered from INIT after the last clear write; RUN has no exit other than reset.
- REQ-016 In INIT, an AW-bit counter SHALL start at 0 and write all-zero words to every bank at the counter address, one address per cycle.
- REQ-017 In INIT, the FSM SHALL go to RUN on the cycle after writing address DEPTH-1, so INIT lasts exactly DEPTH cycles.
- REQ-018 ready SHALL be 0 in INIT and 1 in RUN, registered.
- REQ-019 While ready=0, rd_en and wr_en SHALL be ignored, and dout_vld SHALL stay 0.
- REQ-020 In RUN, wr_en[i]=1 SHALL write din slice i to bank i at wr_addr slice i in that cycle.
- REQ-021 In RUN, rd_en[i]=1 accepted at cycle t SHALL drive dout slice i with the bank word and dout_vld[i]=1 at cycle t+RD_LAT, for exactly one cycle per request.
- REQ-022 Back-to-back reads SHALL sustain one result per bank per cycle, with no bubbles.
- REQ-023 Banks SHALL be fully independent; any mix of reads and writes across banks in one cycle SHALL be legal.
- REQ-024 When dout_vld[i]=0, dout slice i SHALL hold its last value.
- REQ-025 A read at cycle t to an address written at cycle t-1 or earlier SHALL return the written data.
- REQ-026 A same-bank, same-address read and write in one cycle SHALL behave as set by REQ-030.

Reset
- REQ-027 When rstn=0 at a clock edge:
  - FSM goes to INIT and the init counter to 0;
  - ready=0, dout_vld=0, dout=0;
  - all in-flight read pipeline stages are flushed.
- REQ-028 Reset asserted mid-INIT or mid-RUN SHALL restart the full DEPTH-cycle clear.
- REQ-029 Memory contents SHALL NOT be required to survive reset.

Configuration
- REQ-030 Macro RTM_WR_BYPASS_EN:
  - Defined: a same-cycle, same-bank, same-address read/write SHALL return the new din (write-first), via a registered forwarding mux that keeps RD_LAT unchanged.
  - Undefined: such a read SHALL return the old contents (read-first), with no forwarding logic instantiated.

Verification (NUM_BANKS=4, BANK_WIDTH=64, DEPTH=4096, NUM_PIPE=2, RD_LAT=3)
- REQ-031 Release rstn and count cycles -> ready=0 for exactly 4096 cycles, then 1. Read bank 2 address 0x7FF -> dout slice 2 = 0 with dout_vld[2]=1 at t+3.
- REQ-032 Write 0xDEADBEEF_00000001 to bank 0 address 5, then read bank 0 address 5 on the next cycle -> that value at t+3, with dout_vld[0] pulsed for exactly one cycle.
- REQ-033 Stream reads of addresses 0..15 on all banks over 16 consecutive cycles -> dout_vld=4'hF for 16 consecutive cycles, data in order, no gaps.
- REQ-034 Same cycle, bank 1, address 9 holds 0xAA..AA; write 0x55..55 and read address 9 -> 0x55..55 with RTM_WR_BYPASS_EN defined, 0xAA..AA without it.
- REQ-035 Issue 3 reads, then pull rstn low for 1 cycle before their results -> dout_vld never asserts for them, dout=0, ready returns after 4096 cycles.
- REQ-036 Pulse rd_en and wr_en during INIT -> no dout_vld pulse, and after RUN every location reads 0.
